// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU constants used by the front-end stages.
//   XLEN_DEF / INST_W_DEF / RESET_PC_DEF : default widths and reset PC
//   INST_BYTES                           : PC increment per sequential fetch
//   NOP_INST                             : canonical NOP (consumed by decode)
//   cnt_width()                          : width of an occupancy counter that
//                                          must hold the value 'depth'
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          INST_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          INST_BYTES   = 4;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory port, the redirect port and the decode-side
// valid/ready port of the fetch stage.
//   master : fetch_unit side (drives requests and decode outputs)
//   slave  : environment side (memory, branch unit, decode)
// Signals:
//   imem_req_valid / imem_addr  fetch request and word address
//   imem_rdata                  instruction, returned one cycle after request
//   redirect_valid / redirect_pc  restart fetch at a new PC
//   out_valid / out_ready / out_inst / out_pc  head of the fetch buffer
//   fifo_count                  number of buffered entries
// -----------------------------------------------------------------------------
interface fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int INST_W     = 32,
   parameter int FIFO_DEPTH = 4
);

   localparam int CNT_W = cnt_width(FIFO_DEPTH);

   logic              imem_req_valid;
   logic [XLEN-1:0]   imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [XLEN-1:0]   out_pc;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_rdata,
      input  redirect_valid, redirect_pc,
      output out_valid,
      input  out_ready,
      output out_inst, out_pc, fifo_count
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_rdata,
      output redirect_valid, redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_inst, out_pc, fifo_count
   );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with flush for the fetch buffer. Head is read straight from
// storage, so an entry pushed in cycle N is visible at 'head' in cycle N+1.
// Push and pop in the same cycle are legal at any occupancy, including full.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : discard all entries (wins over push/pop)
//   push/wdata: write an entry
//   pop       : remove head (ignored when empty)
//   head      : current head entry (don't-care when empty)
//   count     : occupancy, empty : count == 0
// -----------------------------------------------------------------------------
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Effective push/pop; a pop frees the slot a same-cycle push reuses
   always_comb begin
      full_s    = (count_r == CW'(DEPTH));
      do_pop_s  = pop && (count_r != CW'(0)) && !flush;
      do_push_s = push && !flush && (!full_s || do_pop_s);
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage (no reset needed: contents are qualified by count)
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == CW'(0));

   fetch_fifo_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .count (count_r)
   );

endmodule

// File: rtl/fetch_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_fifo_chk
// Property checker for fetch_fifo: a push that is not matched by a pop must
// never arrive while the buffer is full.
//   clk, rst, flush, push, pop : observed FIFO controls
//   count                      : observed occupancy
// -----------------------------------------------------------------------------
module fetch_fifo_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          flush,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);

   // Overflow guard: upstream issue gating must keep the buffer from overrunning
   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst || flush)
      !(push && !pop && (count == CW'(DEPTH)))
   );

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC, issues one sequential word fetch per
// cycle while buffer space is guaranteed, tags each returning word with its PC
// and queues it for decode. A redirect flushes the buffer, kills the fetch in
// flight and restarts at the (word-aligned) redirect target.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (imem, redirect and decode ports)
// Timing: request in cycle N -> rdata in N+1 -> out_valid in N+2.
// -----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEF,
   parameter int              INST_W     = INST_W_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
   parameter int              FIFO_DEPTH = 4
) (
   input logic          CLK,
   input logic          RST,
   fetch_unit_if.master bus
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int EW = INST_W + XLEN;

   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] tag_r;
   logic            inflight_r;

   logic [CW-1:0]   count_s;
   logic [EW-1:0]   head_s;
   logic            empty_s;
   logic            pop_s;
   logic            push_s;
   logic            issue_s;
   logic [CW:0]     occ_s;

   // Issue/return control. Occupancy counts the word in flight as already
   // buffered and credits a same-cycle pop, so a full buffer that is being
   // drained still sustains one fetch per cycle without ever overflowing.
   always_comb begin
      pop_s   = !empty_s && bus.out_ready;
      occ_s   = {1'b0, count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
      issue_s = !RST && !bus.redirect_valid && (occ_s < (CW+1)'(FIFO_DEPTH));
      // A redirect in the return cycle kills the word arriving now
      push_s  = inflight_r && !bus.redirect_valid && !RST;
   end

   // PC, in-flight flag and PC tag of the outstanding fetch
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_r       <= RESET_PC;
         tag_r      <= RESET_PC;
         inflight_r <= 1'b0;
      end else if (bus.redirect_valid) begin
         pc_r       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         inflight_r <= 1'b0;
      end else if (issue_s) begin
         pc_r       <= pc_r + XLEN'(INST_BYTES);
         tag_r      <= pc_r;
         inflight_r <= 1'b1;
      end else begin
         inflight_r <= 1'b0;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .flush (bus.redirect_valid),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({bus.imem_rdata, tag_r}),
      .head  (head_s),
      .count (count_s),
      .empty (empty_s)
   );

   assign bus.imem_req_valid = issue_s;
   assign bus.imem_addr      = pc_r;
   assign bus.out_valid      = !empty_s;
   assign bus.out_inst       = head_s[EW-1:XLEN];
   assign bus.out_pc         = head_s[XLEN-1:0];
   assign bus.fifo_count     = count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Two fetch units: dut1 (RESET_PC=0) exercises streaming, stall, redirect and
// reset; dut2 (RESET_PC=FFFFFFF8) streams across the address wrap. Memory
// word at address a is A0000000 + a[31:2]. A scoreboard queue per DUT holds
// the expected {inst, pc} stream; monitors compare every accepted head.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32), .INST_W(32), .FIFO_DEPTH(4)) b1 ();
   fetch_unit_if #(.XLEN(32), .INST_W(32), .FIFO_DEPTH(4)) b2 ();

   fetch_unit #(.XLEN(32), .INST_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4))
      u_dut1 (.CLK(clk), .RST(rst), .bus(b1));
   fetch_unit #(.XLEN(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4))
      u_dut2 (.CLK(clk), .RST(rst), .bus(b2));

   int checks   = 0;
   int failures = 0;
   logic [63:0] q1 [$];
   logic [63:0] q2 [$];
   logic [31:0] last_pc1;
   int          cnt_100 = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + {2'b00, a[31:2]};
   endfunction

   // Instruction memories: always ready, data one cycle after the request
   always @(posedge clk) begin
      b1.imem_rdata <= b1.imem_req_valid ? mem_word(b1.imem_addr) : 32'hDEAD_BEEF;
      b2.imem_rdata <= b2.imem_req_valid ? mem_word(b2.imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected stream for a fetch run starting at 'start'
   task automatic seg(input int which, input logic [31:0] start);
      logic [31:0] p;
      if (which == 1) q1.delete();
      else            q2.delete();
      for (int k = 0; k < 64; k++) begin
         p = start + 32'(4 * k);
         if (which == 1) q1.push_back({mem_word(p), p});
         else            q2.push_back({mem_word(p), p});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   // Monitors: compare every handshake against the scoreboard queues
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && b1.out_valid && b1.out_ready) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL mon1_empty: got pc %h expected no delivery", b1.out_pc);
            end else begin
               e = q1.pop_front();
               if ({b1.out_inst, b1.out_pc} !== e) begin
                  failures++;
                  $display("FAIL mon1_entry: got inst %h pc %h expected inst %h pc %h",
                           b1.out_inst, b1.out_pc, e[63:32], e[31:0]);
               end
            end
            last_pc1 = b1.out_pc;
            if (b1.out_pc == 32'h0000_0100) cnt_100++;
         end
         if (rst === 1'b0 && b2.out_valid && b2.out_ready) begin
            checks++;
            if (q2.size() == 0) begin
               failures++;
               $display("FAIL mon2_empty: got pc %h expected no delivery", b2.out_pc);
            end else begin
               e = q2.pop_front();
               if ({b2.out_inst, b2.out_pc} !== e) begin
                  failures++;
                  $display("FAIL mon2_entry: got inst %h pc %h expected inst %h pc %h",
                           b2.out_inst, b2.out_pc, e[63:32], e[31:0]);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      rst = 1'b1;
      b1.out_ready = 1'b1; b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0;
      b2.out_ready = 1'b1; b2.redirect_valid = 1'b0; b2.redirect_pc = 32'h0;
      tick(); tick(); settle();
      chk("rst_req_valid",  32'(b1.imem_req_valid), 32'd0);
      chk("rst_out_valid",  32'(b1.out_valid),      32'd0);
      chk("rst_fifo_count", 32'(b1.fifo_count),     32'd0);
      chk("rst_req_valid2", 32'(b2.imem_req_valid), 32'd0);

      // Streaming from RESET_PC (dut1) and across the wrap (dut2)
      tick(); rst = 1'b0; seg(1, 32'h0); seg(2, 32'hFFFF_FFF8); settle();
      chk("s_req_c0",   32'(b1.imem_req_valid), 32'd1);
      chk("s_addr_c0",  b1.imem_addr, 32'h0000_0000);
      chk("w_addr_c0",  b2.imem_addr, 32'hFFFF_FFF8);
      tick(); settle();
      chk("s_addr_c1",  b1.imem_addr, 32'h0000_0004);
      chk("s_oval_c1",  32'(b1.out_valid), 32'd0);
      chk("w_addr_c1",  b2.imem_addr, 32'hFFFF_FFFC);
      tick(); settle();
      chk("s_oval_c2",  32'(b1.out_valid), 32'd1);
      chk("s_opc_c2",   b1.out_pc, 32'h0000_0000);
      chk("w_addr_c2",  b2.imem_addr, 32'h0000_0000);
      chk("w_opc_c2",   b2.out_pc, 32'hFFFF_FFF8);
      for (int k = 3; k <= 8; k++) begin
         tick(); settle();
         chk("s_addr",  b1.imem_addr, 32'(4 * k));
         chk("w_opc",   b2.out_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
      end
      chk("s_count_steady", 32'(b1.fifo_count), 32'd1);

      // Backpressure: buffer fills to 4, fetch stalls, nothing lost
      tick(); b1.out_ready = 1'b0;
      repeat (9) tick();
      settle();
      chk("bp_count_full", 32'(b1.fifo_count), 32'd4);
      chk("bp_req_off",    32'(b1.imem_req_valid), 32'd0);
      chk("bp_head_pc",    b1.out_pc, 32'h0000_001C);
      tick(); b1.out_ready = 1'b1; settle();
      chk("bp_req_resume", 32'(b1.imem_req_valid), 32'd1);
      chk("bp_addr_resume", b1.imem_addr, 32'h0000_002C);
      repeat (4) tick();
      settle();
      chk("bp_count_after", 32'(b1.fifo_count), 32'd3);

      // Redirect with 3 buffered and one in flight, no pop
      tick(); b1.out_ready = 1'b0; b1.redirect_valid = 1'b1; b1.redirect_pc = 32'h0000_0103;
      settle();
      chk("rd_count_before", 32'(b1.fifo_count), 32'd3);
      chk("rd_req_off",      32'(b1.imem_req_valid), 32'd0);
      tick(); b1.redirect_valid = 1'b0; b1.out_ready = 1'b1; seg(1, 32'h0000_0100); settle();
      chk("rd_count_flushed", 32'(b1.fifo_count), 32'd0);
      chk("rd_oval_flushed",  32'(b1.out_valid), 32'd0);
      chk("rd_req_on",        32'(b1.imem_req_valid), 32'd1);
      chk("rd_addr_target",   b1.imem_addr, 32'h0000_0100);
      tick(); settle();
      chk("rd_addr_next",     b1.imem_addr, 32'h0000_0104);
      chk("rd_oval_gap",      32'(b1.out_valid), 32'd0);

      // Redirect with a simultaneous pop of the head (PC 0x100)
      tick(); b1.redirect_valid = 1'b1; b1.redirect_pc = 32'h0000_0200; settle();
      chk("rp_head_pc",  b1.out_pc, 32'h0000_0100);
      tick(); b1.redirect_valid = 1'b0; seg(1, 32'h0000_0200); settle();
      chk("rp_last_pc",  last_pc1, 32'h0000_0100);
      chk("rp_once",     32'(cnt_100), 32'd1);
      chk("rp_oval",     32'(b1.out_valid), 32'd0);
      chk("rp_addr",     b1.imem_addr, 32'h0000_0200);

      // Back-to-back redirects: the last one wins
      tick(); b1.redirect_valid = 1'b1; b1.redirect_pc = 32'h0000_0300;
      tick(); b1.redirect_pc = 32'h0000_0400;
      tick(); b1.redirect_valid = 1'b0; seg(1, 32'h0000_0400); settle();
      chk("rr_addr",  b1.imem_addr, 32'h0000_0400);
      chk("rr_oval",  32'(b1.out_valid), 32'd0);
      repeat (3) tick();
      settle();
      chk("rr_oval_on", 32'(b1.out_valid), 32'd1);

      // Reset with a full buffer
      tick(); b1.out_ready = 1'b0;
      repeat (3) tick();
      settle();
      chk("mr_count_full", 32'(b1.fifo_count), 32'd4);
      tick(); rst = 1'b1; b1.out_ready = 1'b1; settle();
      chk("mr_req_off", 32'(b1.imem_req_valid), 32'd0);
      tick(); settle();
      chk("mr_oval",   32'(b1.out_valid), 32'd0);
      chk("mr_count",  32'(b1.fifo_count), 32'd0);
      tick(); rst = 1'b0; seg(1, 32'h0); seg(2, 32'hFFFF_FFF8); settle();
      chk("mr_addr_restart",  b1.imem_addr, 32'h0000_0000);
      chk("mr_req_restart",   32'(b1.imem_req_valid), 32'd1);
      chk("mr_addr_restart2", b2.imem_addr, 32'hFFFF_FFF8);
      repeat (6) tick();
      settle();
      chk("mr_oval_after", 32'(b1.out_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
